// File: rtl/shift_exec_stage.sv
// rtl/shift_exec_stage.sv - two-stage RV32 shift unit built on a one-hot multiply core
module shift_exec_stage #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_data,
    input  logic [4:0]       in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag
);

    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    logic             s1_valid_q,  s1_valid_d;
    logic [TAG_W-1:0] s1_tag_q,    s1_tag_d;
    logic [1:0]       s1_op_q,     s1_op_d;
    logic [4:0]       s1_shamt_q,  s1_shamt_d;
    logic [31:0]      s1_data_q,   s1_data_d;
    logic [31:0]      s1_onehot_q, s1_onehot_d;
    logic             s1_sign_q,   s1_sign_d;

    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q,  out_data_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;

    logic        adv1, adv2, accept;
    logic [31:0] left_prod, shifted, fill, result;

    always_comb begin
        adv2     = !out_valid_q || out_ready;
        adv1     = adv2;
        in_ready = !rst && (!s1_valid_q || adv1);
        accept   = in_valid && in_ready && !flush;

        s1_valid_d  = s1_valid_q;
        s1_tag_d    = s1_tag_q;
        s1_op_d     = s1_op_q;
        s1_shamt_d  = s1_shamt_q;
        s1_data_d   = s1_data_q;
        s1_onehot_d = s1_onehot_q;
        s1_sign_d   = s1_sign_q;

        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (in_ready) begin
            s1_valid_d = accept;
        end

        // Right shifts are done as left shifts on the mirrored operand.
        if (accept) begin
            s1_tag_d    = in_tag;
            s1_op_d     = in_op;
            s1_shamt_d  = in_shamt;
            s1_data_d   = in_op[0] ? bit_rev(in_data) : in_data;
            s1_onehot_d = 32'd1 << in_shamt;
            s1_sign_d   = (in_op == 2'b11) && in_data[31];
        end

        left_prod = s1_data_q * s1_onehot_q;
        shifted   = s1_op_q[0] ? bit_rev(left_prod) : left_prod;
        fill      = s1_sign_q ? ~(32'hFFFF_FFFF >> s1_shamt_q) : 32'h0;
        result    = shifted | fill;

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = result;
                out_tag_d  = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= '0;
            s1_op_q     <= 2'b00;
            s1_shamt_q  <= 5'd0;
            s1_data_q   <= 32'h0;
            s1_onehot_q <= 32'h1;
            s1_sign_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_tag_q    <= s1_tag_d;
            s1_op_q     <= s1_op_d;
            s1_shamt_q  <= s1_shamt_d;
            s1_data_q   <= s1_data_d;
            s1_onehot_q <= s1_onehot_d;
            s1_sign_q   <= s1_sign_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

endmodule
